// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: PC register, next-PC selection, run control and imem port sharing with the UART loader.
// Optional single-step out of HALT when STEP_MODE_EN is defined (adds the step input).
module fetch_sequencer #(
  parameter int          PC_W     = 10,
  parameter int          DATA_W   = 32,
  parameter logic [5:0]  HALT_OPC = 6'h3F,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [5:0]        opcjump,
  input  logic              hazardFlag,
  input  logic              branchFlag,
  input  logic [PC_W-1:0]   branchPC,
  input  logic [PC_W-1:0]   jumpPC,
  input  logic              load_req,
  input  logic              load_we,
  input  logic [PC_W-1:0]   load_addr,
  input  logic [DATA_W-1:0] load_data,
`ifdef STEP_MODE_EN
  input  logic              step,
`endif
  output logic              load_gnt,
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_we,
  output logic [DATA_W-1:0] imem_wdata,
  output logic [PC_W-1:0]   PC,
  output logic              flush,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  logic [1:0]      state_reg;
  logic [PC_W-1:0] pc_next;
  logic            advance;
  logic            redirect;
  logic            halt_hit;
  logic            step_fire;
  logic            fetch_fire;

  // Branch is the older instruction, so it beats both halt and jump decode.
  always_comb begin
    pc_next  = PC;
    advance  = 1'b0;
    redirect = 1'b0;
    halt_hit = 1'b0;
    if (branchFlag) begin
      pc_next  = branchPC;
      advance  = 1'b1;
      redirect = 1'b1;
    end else if (opcjump == HALT_OPC) begin
      halt_hit = 1'b1;
    end else if (opcjump == 6'h02 || opcjump == 6'h03) begin
      pc_next  = jumpPC;
      advance  = 1'b1;
      redirect = 1'b1;
    end else if (!hazardFlag) begin
      pc_next  = PC + 1'b1;
      advance  = 1'b1;
    end
  end

`ifdef STEP_MODE_EN
  assign step_fire = (state_reg == ST_HALT) && step && !load_req && !start;
`else
  assign step_fire = 1'b0;
`endif

  assign fetch_fire = ((state_reg == ST_RUN) || step_fire) && !halt_hit;

  // Port mux: the loader only drives imem while it actually holds the grant.
  assign imem_addr  = (state_reg == ST_LOAD) ? load_addr : PC;
  assign imem_we    = (state_reg == ST_LOAD) && load_we && load_gnt;
  assign imem_wdata = load_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      PC          <= '0;
      load_gnt    <= 1'b0;
      flush       <= 1'b0;
      halted      <= 1'b1;
      fetch_count <= '0;
    end else begin
      flush <= 1'b0;
      if (fetch_fire) begin
        PC    <= pc_next;
        flush <= redirect;
        if (advance && fetch_count != {CNT_W{1'b1}})
          fetch_count <= fetch_count + 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (load_req) begin
            state_reg <= ST_LOAD;
            load_gnt  <= 1'b1;
          end else if (start) begin
            state_reg <= ST_RUN;
            PC        <= '0;
            halted    <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (!load_req) begin
            state_reg <= ST_IDLE;
            load_gnt  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (halt_hit) begin
            state_reg <= ST_HALT;
            halted    <= 1'b1;
          end
        end
        ST_HALT: begin
          if (load_req) begin
            state_reg <= ST_LOAD;
            load_gnt  <= 1'b1;
          end else if (start) begin
            state_reg <= ST_RUN;
            halted    <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; step tests are built only when STEP_MODE_EN is defined.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  opcjump;
  logic        hazardFlag;
  logic        branchFlag;
  logic [9:0]  branchPC;
  logic [9:0]  jumpPC;
  logic        load_req;
  logic        load_we;
  logic [9:0]  load_addr;
  logic [31:0] load_data;
  logic        load_gnt;
  logic [9:0]  imem_addr;
  logic        imem_we;
  logic [31:0] imem_wdata;
  logic [9:0]  PC;
  logic        flush;
  logic        halted;
  logic [15:0] fetch_count;
`ifdef STEP_MODE_EN
  logic        step;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .opcjump(opcjump),
    .hazardFlag(hazardFlag), .branchFlag(branchFlag), .branchPC(branchPC), .jumpPC(jumpPC),
    .load_req(load_req), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
`ifdef STEP_MODE_EN
    .step(step),
`endif
    .load_gnt(load_gnt), .imem_addr(imem_addr), .imem_we(imem_we), .imem_wdata(imem_wdata),
    .PC(PC), .flush(flush), .halted(halted), .fetch_count(fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; opcjump = 6'h00; hazardFlag = 1'b0; branchFlag = 1'b0;
    branchPC = '0; jumpPC = '0; load_req = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
`ifdef STEP_MODE_EN
    step = 1'b0;
`endif
    tick(); tick();
    check("rst_pc", PC, 0);
    check("rst_halted", halted, 1);
    check("rst_gnt", load_gnt, 0);
    check("rst_we", imem_we, 0);
    check("rst_flush", flush, 0);
    check("rst_cnt", fetch_count, 0);
    reset = 1'b1;
    tick();

    // Start and sequential fetch
    start = 1'b1; tick(); start = 1'b0;
    check("start_pc", PC, 0);
    check("start_halted", halted, 0);
    tick(); check("seq_pc1", PC, 1);
    tick(); check("seq_pc2", PC, 2);
    tick(); check("seq_pc3", PC, 3);
    check("seq_cnt3", fetch_count, 3);
    check("seq_flush", flush, 0);
    for (int i = 0; i < 4; i++) tick();
    check("seq_pc7", PC, 7);

    // Hazard stall
    hazardFlag = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("stall_pc", PC, 7);
    check("stall_cnt", fetch_count, 7);
    hazardFlag = 1'b0; tick();
    check("release_pc", PC, 8);
    check("release_cnt", fetch_count, 8);

    // Jump then branch+jump+hazard together: back-to-back flushes
    opcjump = 6'h02; jumpPC = 10'h005; tick();
    check("jump_pc", PC, 5);
    check("jump_flush", flush, 1);
    branchFlag = 1'b1; branchPC = 10'h040; jumpPC = 10'h080; hazardFlag = 1'b1; tick();
    branchFlag = 1'b0; opcjump = 6'h00; hazardFlag = 1'b0;
    check("br_pc", PC, 10'h040);
    check("br_flush_b2b", flush, 1);
    check("br_cnt", fetch_count, 10);
    tick();
    check("post_br_pc", PC, 10'h041);
    check("post_br_flush", flush, 0);

    // Wrap at top of address space
    opcjump = 6'h03; jumpPC = 10'h3FF; tick(); opcjump = 6'h00;
    check("top_pc", PC, 10'h3FF);
    tick();
    check("wrap_pc", PC, 0);
    check("wrap_cnt", fetch_count, 13);

    // load_req ignored in RUN, then halt
    opcjump = 6'h02; jumpPC = 10'h008; tick(); opcjump = 6'h00;
    load_req = 1'b1; load_we = 1'b1; load_addr = 10'h123; tick();
    check("run_ld_gnt", load_gnt, 0);
    check("run_ld_pc", PC, 9);
    check("run_imem_addr", imem_addr, 9);
    check("run_imem_we", imem_we, 0);
    load_req = 1'b0; load_we = 1'b0;
    opcjump = 6'h3F; tick(); opcjump = 6'h00;
    check("halt_pc", PC, 9);
    check("halt_halted", halted, 1);
    check("halt_flush", flush, 0);
    check("halt_cnt", fetch_count, 15);
    tick();
    check("halt_hold_pc", PC, 9);
    start = 1'b1; tick(); start = 1'b0;
    check("resume_halted", halted, 0);
    tick();
    check("resume_pc", PC, 10);

    // Halt, then loader burst from HALT
    opcjump = 6'h3F; tick(); opcjump = 6'h00;
    load_req = 1'b1; tick();
    check("ld_gnt", load_gnt, 1);
    check("ld_halted", halted, 1);
    for (int i = 0; i < 4; i++) begin
      load_we = 1'b1; load_addr = 10'(i); load_data = 32'hA5000000 + 32'(i);
      start = (i == 1);
      #1;
      check($sformatf("ld_we%0d", i), imem_we, 1);
      check($sformatf("ld_addr%0d", i), imem_addr, i);
      check($sformatf("ld_data%0d", i), imem_wdata, 32'hA5000000 + 32'(i));
      tick();
    end
    start = 1'b0; load_we = 1'b0;
    check("ld_pc_held", PC, 10);
    check("ld_still_halted", halted, 1);
    load_req = 1'b0; tick();
    check("ld_rel_gnt", load_gnt, 0);
    check("ld_rel_we", imem_we, 0);
    check("idle_halted", halted, 1);
    start = 1'b1; tick(); start = 1'b0;
    check("idle_start_pc", PC, 0);
    tick();
    check("idle_run_pc", PC, 1);

    // Async reset in the middle of a load burst
    opcjump = 6'h3F; tick(); opcjump = 6'h00;
    load_req = 1'b1; tick();
    load_we = 1'b1;
    #1;
    check("mid_ld_we", imem_we, 1);
    reset = 1'b0;
    #1;
    check("arst_gnt", load_gnt, 0);
    check("arst_we", imem_we, 0);
    check("arst_pc", PC, 0);
    check("arst_cnt", fetch_count, 0);
    load_req = 1'b0; load_we = 1'b0;
    #1 reset = 1'b1;
    tick();

`ifdef STEP_MODE_EN
    start = 1'b1; tick(); start = 1'b0;
    opcjump = 6'h02; jumpPC = 10'd20; tick();
    opcjump = 6'h3F; tick(); opcjump = 6'h00;
    check("st_halt_pc", PC, 20);
    step = 1'b1; tick(); step = 1'b0;
    check("st_pc", PC, 21);
    check("st_halted", halted, 1);
    check("st_cnt", fetch_count, 2);
    tick();
    check("st_hold_pc", PC, 21);
    step = 1'b1; load_req = 1'b1; tick(); step = 1'b0;
    check("st_ld_gnt", load_gnt, 1);
    check("st_ld_pc", PC, 21);
    load_req = 1'b0; tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
